// File: rtl/dso_host_cmd_mstr.sv
// Host-side UART command master: sends a 24-bit command as three 8N1 frames
// (high byte first) and receives single-byte responses from the DSO.
module dso_host_cmd_mstr #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        tx_busy,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic        frame_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------- transmit path ----------------
  logic [1:0]    tx_state_reg, tx_state_next;
  logic [23:0]   tx_shift_reg, tx_shift_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [1:0]    tx_byte_reg, tx_byte_next;
  logic          tx_reg, tx_next;
  logic          cmd_sent_reg, cmd_sent_next;
  logic          tx_busy_reg, tx_busy_next;
  logic [7:0]    tx_cur_byte;
  logic          tx_bit_done;

  // The byte on the wire always sits in the top of the shift register.
  assign tx_cur_byte = tx_shift_reg[23:16];
  assign tx_bit_done = (tx_cnt_reg == BIT_LAST);

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_shift_next = tx_shift_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_byte_next  = tx_byte_reg;
    tx_next       = tx_reg;
    cmd_sent_next = cmd_sent_reg;
    tx_busy_next  = tx_busy_reg;
    if (tx_state_reg != S_IDLE) begin
      tx_cnt_next = tx_bit_done ? '0 : tx_cnt_reg + 1'b1;
    end
    case (tx_state_reg)
      S_IDLE: begin
        if (send_cmd) begin
          tx_shift_next = cmd;
          tx_byte_next  = 2'd0;
          tx_bit_next   = 3'd0;
          tx_cnt_next   = '0;
          cmd_sent_next = 1'b0;
          tx_busy_next  = 1'b1;
          tx_next       = 1'b0;
          tx_state_next = S_START;
        end
      end
      S_START: begin
        if (tx_bit_done) begin
          tx_bit_next   = 3'd0;
          tx_next       = tx_cur_byte[0];
          tx_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_bit_done) begin
          if (tx_bit_reg == 3'd7) begin
            tx_next       = 1'b1;
            tx_state_next = S_STOP;
          end else begin
            tx_bit_next = tx_bit_reg + 3'd1;
            tx_next     = tx_cur_byte[tx_bit_reg + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (tx_bit_done) begin
          if (tx_byte_reg == 2'd2) begin
            cmd_sent_next = 1'b1;
            tx_busy_next  = 1'b0;
            tx_state_next = S_IDLE;
          end else begin
            // next frame starts straight after this stop bit, no idle gap
            tx_byte_next  = tx_byte_reg + 2'd1;
            tx_shift_next = {tx_shift_reg[15:0], 8'h00};
            tx_next       = 1'b0;
            tx_state_next = S_START;
          end
        end
      end
      default: tx_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= S_IDLE;
      tx_shift_reg <= '0;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_byte_reg  <= '0;
      tx_reg       <= 1'b1;
      cmd_sent_reg <= 1'b0;
      tx_busy_reg  <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_shift_reg <= tx_shift_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_byte_reg  <= tx_byte_next;
      tx_reg       <= tx_next;
      cmd_sent_reg <= cmd_sent_next;
      tx_busy_reg  <= tx_busy_next;
    end
  end

  assign TX       = tx_reg;
  assign cmd_sent = cmd_sent_reg;
  assign tx_busy  = tx_busy_reg;

  // ---------------- receive path ----------------
  logic [1:0]    rx_sync_reg;
  logic          rx_line;
  logic [1:0]    rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic [7:0]    resp_reg, resp_next;
  logic          resp_rdy_reg, resp_rdy_next;
  logic          frame_err_reg, frame_err_next;
  logic          rx_start_ok;
  logic          rx_byte_done;

  assign rx_line = rx_sync_reg[1];

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_start_ok   = 1'b0;
    rx_byte_done  = 1'b0;
    case (rx_state_reg)
      S_IDLE: begin
        if (!rx_line) begin
          rx_cnt_next   = '0;
          rx_state_next = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next = '0;
          if (rx_line) begin
            rx_state_next = S_IDLE;
          end else begin
            rx_start_ok   = 1'b1;
            rx_bit_next   = 3'd0;
            rx_state_next = S_DATA;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_line, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) begin
            rx_state_next = S_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + 3'd1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_byte_done  = 1'b1;
          rx_state_next = S_IDLE;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  // resp_rdy drops only on a confirmed start, so a low stop bit that drags
  // into IDLE and is rejected as a glitch does not hide the byte just taken.
  always_comb begin
    resp_next      = rx_byte_done ? rx_shift_reg : resp_reg;
    resp_rdy_next  = resp_rdy_reg;
    frame_err_next = frame_err_reg;
    if (rx_byte_done) begin
      resp_rdy_next = 1'b1;
    end else if (clr_resp_rdy || rx_start_ok) begin
      resp_rdy_next = 1'b0;
    end
    if (rx_byte_done && !rx_line) begin
      frame_err_next = 1'b1;
    end else if (clr_resp_rdy) begin
      frame_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_reg   <= 2'b11;
      rx_state_reg  <= S_IDLE;
      rx_cnt_reg    <= '0;
      rx_bit_reg    <= '0;
      rx_shift_reg  <= '0;
      resp_reg      <= 8'h00;
      resp_rdy_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_sync_reg   <= {rx_sync_reg[0], RX};
      rx_state_reg  <= rx_state_next;
      rx_cnt_reg    <= rx_cnt_next;
      rx_bit_reg    <= rx_bit_next;
      rx_shift_reg  <= rx_shift_next;
      resp_reg      <= resp_next;
      resp_rdy_reg  <= resp_rdy_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign resp      = resp_reg;
  assign resp_rdy  = resp_rdy_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_dso_host_cmd_mstr.sv
// Bench for dso_host_cmd_mstr: table-driven command/response vectors, hand
// sequences for the timing corner cases, and randomized traffic vs a model.
module tb_dso_host_cmd_mstr;

  localparam int B     = 16;
  localparam int FRAME = 30 * B;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        tx_busy;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;
  logic        frame_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dso_host_cmd_mstr #(.BAUD_DIV(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .send_cmd     (send_cmd),
    .cmd_sent     (cmd_sent),
    .tx_busy      (tx_busy),
    .TX           (TX),
    .RX           (RX),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy),
    .frame_err    (frame_err)
  );

  typedef struct {
    logic [23:0] cmd;
    logic [23:0] wire_bytes;  // expected bytes in wire order, first in [23:16]
    int          poke_k;      // cycle offset of a second send_cmd, -1 = none
    logic [23:0] poke_cmd;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr_first;
    logic [7:0] exp_resp;
    logic       exp_rdy;
    logic       exp_fe;
  } rx_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line level k clocks after acceptance: 10 bit slots per byte,
  // start=0, eight data bits LSB first, stop=1.
  function automatic logic tx_exp(input logic [23:0] bytes, input int k);
    int slot = k / B;
    int j    = slot / 10;
    int pos  = slot % 10;
    logic [7:0] bv;
    bv = bytes[23 - 8*j -: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return bv[pos - 1];
  endfunction

  task automatic chk_reset_state(input string nm);
    chk({nm, "_tx"}, TX, 1);
    chk({nm, "_cmd_sent"}, cmd_sent, 0);
    chk({nm, "_tx_busy"}, tx_busy, 0);
    chk({nm, "_resp"}, resp, 8'h00);
    chk({nm, "_resp_rdy"}, resp_rdy, 0);
    chk({nm, "_frame_err"}, frame_err, 0);
  endtask

  // Sends c and checks every clock of the line against the expected bytes.
  task automatic xmit_check(input string nm, input logic [23:0] c, input logic [23:0] wire_bytes,
                            input int poke_k, input logic [23:0] poke_cmd, input int rst_k);
    cmd      = c;
    send_cmd = 1'b1;
    step();
    send_cmd = 1'b0;
    cmd      = ~c;
    for (int k = 0; k < FRAME; k++) begin
      if (k == rst_k) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state({nm, "_after_rst"});
        return;
      end
      chk($sformatf("%s_tx_k%0d", nm, k), TX, tx_exp(wire_bytes, k));
      chk($sformatf("%s_busy_k%0d", nm, k), tx_busy, 1);
      chk($sformatf("%s_sent_k%0d", nm, k), cmd_sent, 0);
      if (k == poke_k) begin
        cmd      = poke_cmd;
        send_cmd = 1'b1;
      end
      step();
      send_cmd = 1'b0;
    end
    chk({nm, "_cmd_sent_end"}, cmd_sent, 1);
    chk({nm, "_busy_end"}, tx_busy, 0);
    chk({nm, "_tx_end"}, TX, 1);
  endtask

  task automatic idle_check(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_idle_tx_%0d", nm, i), TX, 1);
      chk($sformatf("%s_idle_busy_%0d", nm, i), tx_busy, 0);
      chk($sformatf("%s_idle_sent_%0d", nm, i), cmd_sent, 1);
      step();
    end
  endtask

  task automatic clr_pulse();
    clr_resp_rdy = 1'b1;
    step();
    clr_resp_rdy = 1'b0;
  endtask

  // Drives one 8N1 frame on RX; returns just after the stop bit ends.
  task automatic rx_frame(input logic [7:0] d, input logic stop_v, input logic clr_first,
                          input logic [7:0] prev_resp);
    RX = 1'b0;
    for (int i = 0; i < B; i++) begin
      if (i == 0 && clr_first) clr_resp_rdy = 1'b1;
      step();
      clr_resp_rdy = 1'b0;
    end
    if (clr_first) begin
      chk("rx_rdy_cleared_in_start", resp_rdy, 0);
      chk("rx_resp_held_in_start", resp, prev_resp);
    end
    for (int b = 0; b < 8; b++) begin
      RX = d[b];
      repeat (B) step();
    end
    RX = stop_v;
    repeat (B) step();
    RX = 1'b1;
  endtask

  initial begin
    tx_vec_t     tx_tab[2];
    rx_vec_t     rx_tab[2];
    logic [23:0] c;
    logic [7:0]  d;
    logic [7:0]  prev;
    logic        sv;
    logic [7:0]  resp_m;
    logic        rdy_m;
    logic        fe_m;
    int          gap;

    tx_tab[0] = '{cmd: 24'h082ABB, wire_bytes: {8'h08, 8'h2A, 8'hBB}, poke_k: -1, poke_cmd: 24'h0};
    tx_tab[1] = '{cmd: 24'h082ABB, wire_bytes: {8'h08, 8'h2A, 8'hBB}, poke_k: 15*B, poke_cmd: 24'h090000};
    rx_tab[0] = '{data: 8'hA5, stop: 1'b1, clr_first: 1'b0, exp_resp: 8'hA5, exp_rdy: 1'b1, exp_fe: 1'b0};
    rx_tab[1] = '{data: 8'hB8, stop: 1'b1, clr_first: 1'b1, exp_resp: 8'hB8, exp_rdy: 1'b1, exp_fe: 1'b0};

    rst          = 1'b1;
    send_cmd     = 1'b0;
    clr_resp_rdy = 1'b0;
    RX           = 1'b1;
    cmd          = 24'h0;
    repeat (3) step();
    chk_reset_state("reset");
    rst = 1'b0;
    step();

    // commands: plain send, then a send with a dropped mid-transfer request
    for (int i = 0; i < 2; i++) begin
      xmit_check($sformatf("tx_tab%0d", i), tx_tab[i].cmd, tx_tab[i].wire_bytes,
                 tx_tab[i].poke_k, tx_tab[i].poke_cmd, -1);
      idle_check($sformatf("tx_tab%0d", i), 2*B);
    end

    // request in the cycle cmd_sent rises is dropped; the next cycle's is taken
    xmit_check("same_cycle_a", 24'h123456, 24'h123456, FRAME-1, 24'h0A0B0C, -1);
    xmit_check("same_cycle_b", 24'h0A0B0C, 24'h0A0B0C, -1, 24'h0, -1);

    // back-to-back responses with a clear between them
    prev = 8'h00;
    for (int i = 0; i < 2; i++) begin
      rx_frame(rx_tab[i].data, rx_tab[i].stop, rx_tab[i].clr_first, prev);
      chk($sformatf("rx_tab%0d_resp", i), resp, rx_tab[i].exp_resp);
      chk($sformatf("rx_tab%0d_rdy", i), resp_rdy, rx_tab[i].exp_rdy);
      chk($sformatf("rx_tab%0d_fe", i), frame_err, rx_tab[i].exp_fe);
      prev = rx_tab[i].exp_resp;
    end
    repeat (B) step();

    // stop bit low
    rx_frame(8'h5A, 1'b0, 1'b0, prev);
    chk("bad_stop_resp", resp, 8'h5A);
    chk("bad_stop_rdy", resp_rdy, 1);
    chk("bad_stop_fe", frame_err, 1);
    repeat (B) step();
    clr_pulse();
    chk("bad_stop_clr_rdy", resp_rdy, 0);
    chk("bad_stop_clr_fe", frame_err, 0);

    // short glitch, then a real byte
    RX = 1'b0;
    repeat (5) step();
    RX = 1'b1;
    repeat (2*B) step();
    chk("glitch_rdy", resp_rdy, 0);
    chk("glitch_resp", resp, 8'h5A);
    rx_frame(8'h3C, 1'b1, 1'b0, 8'h5A);
    chk("after_glitch_resp", resp, 8'h3C);
    chk("after_glitch_rdy", resp_rdy, 1);
    chk("after_glitch_fe", frame_err, 0);
    repeat (B) step();

    // reset in the data phase of the second byte, then a clean command
    xmit_check("rst_mid", 24'h082ABB, 24'h082ABB, -1, 24'h0, 13*B + 5);
    step();
    xmit_check("post_rst", 24'h0600FF, {8'h06, 8'h00, 8'hFF}, -1, 24'h0, -1);

    // random commands
    for (int i = 0; i < 4; i++) begin
      c = 24'($urandom);
      xmit_check($sformatf("rnd_tx%0d", i), c, c, -1, 24'h0, -1);
      repeat ($urandom_range(0, 3)) step();
    end

    // random responses against the model
    resp_m = 8'h00;
    rdy_m  = 1'b0;
    fe_m   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        clr_pulse();
        rdy_m = 1'b0;
        fe_m  = 1'b0;
      end
      d  = 8'($urandom);
      sv = ($urandom_range(0, 9) != 0);
      rx_frame(d, sv, 1'b0, resp_m);
      resp_m = d;
      rdy_m  = 1'b1;
      fe_m   = fe_m | ~sv;
      chk($sformatf("rnd_rx%0d_resp", i), resp, resp_m);
      chk($sformatf("rnd_rx%0d_rdy", i), resp_rdy, rdy_m);
      chk($sformatf("rnd_rx%0d_fe", i), frame_err, fe_m);
      gap = sv ? $urandom_range(0, 3) : B + $urandom_range(0, 3);
      repeat (gap) step();
    end
    repeat (B) step();

    // full duplex
    c = 24'($urandom);
    fork
      xmit_check("duplex_tx", c, c, -1, 24'h0, -1);
      begin
        for (int i = 0; i < 3; i++) begin
          d = 8'($urandom);
          rx_frame(d, 1'b1, 1'b0, resp_m);
          resp_m = d;
          chk($sformatf("duplex_rx%0d_resp", i), resp, resp_m);
          chk($sformatf("duplex_rx%0d_rdy", i), resp_rdy, 1);
          chk($sformatf("duplex_rx%0d_fe", i), frame_err, fe_m);
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
